// File: rtl/sev_seg_scan_if.sv
// Load bus between the result producer and the seven-segment scanner.
//   value        : result to display
//   signed_mode  : 1 = value is two's complement
//   err_in       : 1 = show the error glyph instead of the value
//   value_valid  : single-cycle load strobe
//   busy         : conversion in progress; strobes are dropped while high
interface sev_seg_scan_if #(
    parameter int IN_WIDTH = 16
);
    logic [IN_WIDTH-1:0] value;
    logic                signed_mode;
    logic                err_in;
    logic                value_valid;
    logic                busy;

    modport master (output value, signed_mode, err_in, value_valid, input busy);
    modport slave  (input value, signed_mode, err_in, value_valid, output busy);
endinterface

// File: rtl/sev_seg_scan.sv
// Four-digit common-anode seven-segment driver.
// A loaded result is converted to BCD by a sequential double-dabble engine,
// formatted (sign, leading-zero blanking, overflow dashes, "Err "), and then
// scanned one digit per rising edge of the refresh clock.
//   clk, rst_n  : system clock, synchronous active-low reset
//   refresh_in  : divided refresh clock (same domain, sampled as data)
//   ld          : load bus (slave side), see sev_seg_scan_if
//   an          : digit enables, an[0] = rightmost digit
//   seg         : cathodes {g,f,e,d,c,b,a}
//   dp          : decimal point, always off
module sev_seg_scan #(
    parameter int IN_WIDTH       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 refresh_in,
    sev_seg_scan_if.slave        ld,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);
    // Enough BCD digits for IN_WIDTH bits, never fewer than five so the
    // overflow test above digit 3 always has a nibble to look at.
    localparam int NDIG_MIN = (IN_WIDTH * 30103) / 100000 + 1;
    localparam int NDIG     = (NDIG_MIN > 5) ? NDIG_MIN : 5;
    localparam int BCD_W    = 4 * NDIG;
    localparam int CW       = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_FMT  = 2'd2;

    // Internal glyph codes: 0..9 are digits.
    localparam logic [3:0] G_DASH  = 4'd10;
    localparam logic [3:0] G_BLANK = 4'd11;
    localparam logic [3:0] G_E     = 4'd12;
    localparam logic [3:0] G_R     = 4'd13;

    logic [1:0]          state_q, state_d;
    logic [IN_WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_q, neg_d, err_q, err_d;
    logic [3:0][3:0]     dig_q, dig_d, fmt;
    logic                refresh_d_q;
    logic [1:0]          scan_idx_q;
    logic [3:0]          an_q;
    logic [6:0]          seg_q;
    logic                tick;

    function automatic logic [6:0] seg7(input logic [3:0] g);
        logic [6:0] s;
        case (g)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            G_DASH:  s = 7'b0111111;
            G_E:     s = 7'b0000110;
            G_R:     s = 7'b0101111;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Double-dabble correction step on every nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++)
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    // Display formatting from the finished BCD value.
    always_comb begin
        logic [3:0][3:0] bd;
        logic hi4, hi3, z3, z2, z1;
        for (int i = 0; i < 4; i++) bd[i] = bcd_q[4*i +: 4];
        hi4 = |bcd_q[BCD_W-1:16];
        hi3 = hi4 | (bd[3] != 4'd0);
        z3  = (bd[3] == 4'd0);
        z2  = z3 & (bd[2] == 4'd0);
        z1  = z2 & (bd[1] == 4'd0);
        fmt[3] = z3 ? G_BLANK : bd[3];
        fmt[2] = z2 ? G_BLANK : bd[2];
        fmt[1] = z1 ? G_BLANK : bd[1];
        fmt[0] = bd[0];
        if (err_q)
            fmt = {G_E, G_R, G_R, G_BLANK};
        else if (neg_q ? hi3 : hi4)
            fmt = {4{G_DASH}};
        else if (neg_q)
            fmt[3] = G_DASH;   // magnitude <= 999 here, so digit 3 was blank
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        err_d   = err_q;
        dig_d   = dig_q;
        case (state_q)
            S_IDLE: if (ld.value_valid) begin
                neg_d   = ld.signed_mode & ld.value[IN_WIDTH-1];
                err_d   = ld.err_in;
                mag_d   = neg_d ? (IN_WIDTH'(0) - ld.value) : ld.value;
                bcd_d   = '0;
                cnt_d   = CW'(IN_WIDTH);
                state_d = S_CONV;
            end
            S_CONV: begin
                {bcd_d, mag_d} = {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FMT;
            end
            S_FMT: begin
                dig_d   = fmt;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tick    = refresh_in & ~refresh_d_q;
    assign ld.busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            dig_q       <= {G_BLANK, G_BLANK, G_BLANK, 4'd0};
            refresh_d_q <= 1'b0;
            scan_idx_q  <= 2'd0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            dig_q       <= dig_d;
            refresh_d_q <= refresh_in;
            if (tick) scan_idx_q <= scan_idx_q + 2'd1;
            // Registered from the pre-edge index: outputs lag the scan by one cycle.
            an_q  <= ~(4'b0001 << scan_idx_q);
            seg_q <= seg7(dig_q[scan_idx_q]);
        end
    end

    // Registers hold active-low codes; flip at the pins for active-high boards.
    assign an  = an_q  ^ {4{~AN_ACTIVE_LOW}};
    assign seg = seg_q ^ {7{~SEG_ACTIVE_LOW}};
    assign dp  = SEG_ACTIVE_LOW;
endmodule
